bcd_serial_addsub: RTL

Digit-serial BCD adder/subtractor for multi-digit unsigned BCD operands. Processes one digit per clock, LSD first, with a registered decimal carry/borrow. Subtraction is done by 9's complement plus carry-in. A negative difference is converted to sign-magnitude form in a second serial pass (recomplement). This completes the subtract path by turning raw 10's-complement results into a signed, displayable magnitude. It is the area-lean sequential counterpart of the combinational per-digit adder/subtractor chain.

---
 rtl/bcd_serial_addsub.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, with a
// second serial recomplement pass that turns a negative difference into sign-magnitude.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   z,
    output logic                  sign,
    output logic                  ovf
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        FIX,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic                  op_q, op_d;
    logic [4*DIGITS-1:0]   x_q, x_d;
    logic [4*DIGITS-1:0]   y_q, y_d;
    logic [4*DIGITS-1:0]   z_q, z_d;
    logic                  sign_q, sign_d;
    logic                  ovf_q, ovf_d;

    logic [3:0] x_dig, y_dig, z_dig;
    logic [3:0] add_a, add_b;
    logic [4:0] dig_res;

    // One decimal digit: binary sum, then +6 correction when it exceeds 9.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9)
            return {1'b1, 4'(s + 5'd6)};
        else
            return {1'b0, s[3:0]};
    endfunction

    assign x_dig = x_q[idx_q*4 +: 4];
    assign y_dig = y_q[idx_q*4 +: 4];
    assign z_dig = z_q[idx_q*4 +: 4];

    // FIX reuses the same digit adder: 9's complement of the stored digit plus carry.
    always_comb begin
        if (state_q == FIX) begin
            add_a = 4'd9 - z_dig;
            add_b = 4'd0;
        end else begin
            add_a = x_dig;
            add_b = op_q ? y_dig : (4'd9 - y_dig);
        end
        dig_res = bcd_digit_add(add_a, add_b, carry_q);
    end

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    op_d    = op;
                    sign_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    carry_d = ~op;
                    state_d = ADD;
                end
            end
            ADD: begin
                z_d[idx_q*4 +: 4] = dig_res[3:0];
                carry_d           = dig_res[4];
                idx_d             = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (op_q) begin
                        ovf_d   = dig_res[4];
                        state_d = DONE;
                    end else if (dig_res[4]) begin
                        state_d = DONE;
                    end else begin
                        // No end-around carry: the difference is negative.
                        sign_d  = 1'b1;
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                z_d[idx_q*4 +: 4] = dig_res[3:0];
                carry_d           = dig_res[4];
                idx_d             = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ADD) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign z    = z_q;
    assign sign = sign_q;
    assign ovf  = ovf_q;

endmodule
